// File: rtl/div_share_ctrl.sv
// Round-robin front end that shares one unsigned iterative divider among NREQ issue ports.
// Maps RISC-V DIV/DIVU/REM/REMU onto the core and resolves divide-by-zero and overflow locally.
module div_share_ctrl #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [32*NREQ-1:0]    req_a,
   input  logic [32*NREQ-1:0]    req_b,
   input  logic [TAG_W*NREQ-1:0] req_tag,
   output logic [NREQ-1:0]       req_ready,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [31:0]           res_data,
   output logic [TAG_W-1:0]      res_tag,
   output logic [1:0]            res_src,
   output logic                  div_start,
   output logic [31:0]           div_dividend,
   output logic [31:0]           div_divisor,
   input  logic                  div_done,
   input  logic [31:0]           div_quot,
   input  logic [31:0]           div_rem
);

   typedef enum logic [2:0] {StIdle, StStart, StWait, StFix, StOut} state_e;

   state_e             state_q, state_d;
   logic [1:0]         rr_ptr_q, rr_ptr_d;
   logic [1:0]         op_q, op_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [1:0]         src_q, src_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [31:0]        dividend_q, dividend_d;
   logic [31:0]        divisor_q, divisor_d;
   logic [31:0]        quot_q, quot_d;
   logic [31:0]        rem_q, rem_d;
   logic [31:0]        res_q, res_d;

   logic [2*NREQ-1:0]  valid_dup;
   logic [NREQ-1:0]    valid_rot;
   logic               found;
   logic [1:0]         gnt;

   // Rotate the valids so bit 0 is the requester at rr_ptr, then take the first set bit.
   always_comb begin
      valid_dup = {req_valid, req_valid};
      valid_rot = NREQ'(valid_dup >> rr_ptr_q);
      found     = 1'b0;
      gnt       = '0;
      req_ready = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && valid_rot[i]) begin
            found = 1'b1;
            gnt   = 2'((32'(rr_ptr_q) + i) % NREQ);
         end
      end
      if (state_q == StIdle && found) begin
         req_ready = NREQ'(1) << gnt;
      end
   end

   logic [1:0]         sel_op;
   logic [31:0]        sel_a, sel_b;
   logic [TAG_W-1:0]   sel_tag;
   logic               sel_signed, sel_sa, sel_sb;
   logic [31:0]        q_fix, r_fix;

   always_comb begin
      sel_op     = 2'(req_op >> (32'(gnt) * 2));
      sel_a      = 32'(req_a >> (32'(gnt) * 32));
      sel_b      = 32'(req_b >> (32'(gnt) * 32));
      sel_tag    = TAG_W'(req_tag >> (32'(gnt) * TAG_W));
      sel_signed = ~sel_op[0];
      sel_sa     = sel_signed & sel_a[31];
      sel_sb     = sel_signed & sel_b[31];
      // Sign flags are zero for unsigned ops, so the fix-up passes them through untouched.
      q_fix      = (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
      r_fix      = sign_a_q ? -rem_q : rem_q;

      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      op_d       = op_q;
      tag_d      = tag_q;
      src_d      = src_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      res_d      = res_q;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               op_d       = sel_op;
               tag_d      = sel_tag;
               src_d      = gnt;
               sign_a_d   = sel_sa;
               sign_b_d   = sel_sb;
               dividend_d = sel_sa ? -sel_a : sel_a;
               divisor_d  = sel_sb ? -sel_b : sel_b;
               rr_ptr_d   = 2'((32'(gnt) + 32'd1) % NREQ);
               if (sel_b == '0) begin
                  res_d   = sel_op[1] ? sel_a : '1;
                  state_d = StOut;
               end else if (sel_signed && sel_a == 32'h8000_0000 && sel_b == '1) begin
                  res_d   = sel_op[1] ? '0 : 32'h8000_0000;
                  state_d = StOut;
               end else begin
                  state_d = StStart;
               end
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            if (div_done) begin
               quot_d  = div_quot;
               rem_d   = div_rem;
               state_d = StFix;
            end
         end
         StFix: begin
            res_d   = op_q[1] ? r_fix : q_fix;
            state_d = StOut;
         end
         StOut: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         op_q       <= '0;
         tag_q      <= '0;
         src_q      <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         op_q       <= op_d;
         tag_q      <= tag_d;
         src_q      <= src_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         res_q      <= res_d;
      end
   end

   assign res_valid    = (state_q == StOut);
   assign div_start    = (state_q == StStart);
   assign res_data     = res_q;
   assign res_tag      = tag_q;
   assign res_src      = src_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl, paired with a fixed-latency (L=4) unsigned divider model.
module tb_div_share_ctrl;

   localparam int unsigned NREQ  = 2;
   localparam int unsigned TAG_W = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_op;
   logic [32*NREQ-1:0]    req_a;
   logic [32*NREQ-1:0]    req_b;
   logic [TAG_W*NREQ-1:0] req_tag;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic                  res_ready;
   logic [31:0]           res_data;
   logic [TAG_W-1:0]      res_tag;
   logic [1:0]            res_src;
   logic                  div_start;
   logic [31:0]           div_dividend;
   logic [31:0]           div_divisor;
   logic                  div_done;
   logic [31:0]           div_quot;
   logic [31:0]           div_rem;

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   div_share_ctrl #(
      .NREQ  (NREQ),
      .TAG_W (TAG_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_tag      (req_tag),
      .req_ready    (req_ready),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_tag      (res_tag),
      .res_src      (res_src),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_done     (div_done),
      .div_quot     (div_quot),
      .div_rem      (div_rem)
   );

   // Divider core model: div_done pulses 4 cycles after the div_start cycle.
   logic [2:0]  core_cnt = '0;
   logic        core_done = 1'b0;
   logic        inj_done;
   logic [31:0] core_q = '0;
   logic [31:0] core_r = '0;

   assign div_done = core_done | inj_done;
   assign div_quot = core_q;
   assign div_rem  = core_r;

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (!rst) begin
         core_cnt <= '0;
      end else if (div_start) begin
         core_cnt <= 3'd3;
         core_q   <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
         core_r   <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 3'd1;
         if (core_cnt == 3'd1) core_done <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (div_start) start_cnt <= start_cnt + 1;
   end

   typedef struct {
      int               src;
      logic [1:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [31:0]      ma;
      logic [31:0]      mb;
      logic [31:0]      exp;
      logic [TAG_W-1:0] tag;
   } vec_t;

   task automatic drive_req(input int s, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] tag);
      req_valid[s]              = 1'b1;
      req_op[2*s +: 2]          = op;
      req_a[32*s +: 32]         = a;
      req_b[32*s +: 32]         = b;
      req_tag[TAG_W*s +: TAG_W] = tag;
   endtask

   // Entered at a negedge; returns at the negedge just after the accepting edge.
   task automatic issue(input int s, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, output bit ok);
      drive_req(s, op, a, b, tag);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         ok = req_ready[s];
         @(negedge clk);
         if (ok) break;
      end
      req_valid[s] = 1'b0;
   endtask

   // n counts cycles after the accept edge until res_valid is seen (1 = first cycle).
   task automatic wait_res(output int n);
      n = 1;
      while (!res_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || div_start !== 1'b0 || req_ready !== '0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got res_valid=%b div_start=%b req_ready=%b want 0/0/00",
                  res_valid, div_start, req_ready);
      end
      n_checks++;
      if (res_data !== '0 || res_tag !== '0 || res_src !== '0) begin
         n_errors++;
         $display("FAIL reset_res: got data=%h tag=%h src=%0d want all zero",
                  res_data, res_tag, res_src);
      end
      n_checks++;
      if (div_dividend !== '0 || div_divisor !== '0) begin
         n_errors++;
         $display("FAIL reset_operands: got %h/%h want 0/0", div_dividend, div_divisor);
      end
      req_valid = 2'b11;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_errors++;
         $display("FAIL reset_rr_ptr: got req_ready=%b want 01", req_ready);
      end
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n;
      logic [NREQ-1:0] exp_g;
      drive_req(0, 2'b01, 32'd100, 32'd7, 4'h1);
      drive_req(1, 2'b01, 32'd100, 32'd9, 4'h2);
      for (int j = 0; j < 4; j++) begin
         exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         n_checks++;
         if (req_ready !== exp_g) begin
            n_errors++;
            $display("FAIL rr_grant[%0d]: got %b want %b", j, req_ready, exp_g);
         end
         @(negedge clk);
         wait_res(n);
         n_checks++;
         if (n != 7 || res_src !== 2'(j % 2)) begin
            n_errors++;
            $display("FAIL rr_result[%0d]: got latency=%0d src=%0d want 7/%0d", j, n, res_src,
                     j % 2);
         end
         n_checks++;
         if (res_data !== ((j % 2 == 0) ? 32'd14 : 32'd11) ||
             res_tag !== ((j % 2 == 0) ? 4'h1 : 4'h2)) begin
            n_errors++;
            $display("FAIL rr_data[%0d]: got data=%h tag=%h", j, res_data, res_tag);
         end
         if (j == 3) req_valid = '0;
         handshake();
      end
   endtask

   task automatic test_normal_ops();
      vec_t v[8];
      bit ok;
      int n;
      v[0] = '{0, 2'b00, 32'hFFFF_FFF9, 32'd2,        32'd7,        32'd2,        32'hFFFF_FFFD, 4'h5};
      v[1] = '{1, 2'b10, 32'hFFFF_FFF9, 32'd2,        32'd7,        32'd2,        32'hFFFF_FFFF, 4'h9};
      v[2] = '{0, 2'b11, 32'd7,         32'hFFFF_FFFE, 32'd7,       32'hFFFF_FFFE, 32'd7,        4'h3};
      v[3] = '{1, 2'b00, 32'd7,         32'hFFFF_FFFE, 32'd7,       32'd2,        32'hFFFF_FFFD, 4'hA};
      v[4] = '{0, 2'b10, 32'd7,         32'hFFFF_FFFE, 32'd7,       32'd2,        32'd1,        4'h1};
      v[5] = '{1, 2'b01, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC, 4'h2};
      v[6] = '{0, 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd7,       32'd2,        32'd3,        4'h4};
      v[7] = '{1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      4'hC};
      for (int i = 0; i < 8; i++) begin
         issue(v[i].src, v[i].op, v[i].a, v[i].b, v[i].tag, ok);
         n_checks++;
         if (!ok || div_start !== 1'b1) begin
            n_errors++;
            $display("FAIL op_start[%0d]: got granted=%b div_start=%b want 1/1", i, ok, div_start);
         end
         n_checks++;
         if (div_dividend !== v[i].ma || div_divisor !== v[i].mb) begin
            n_errors++;
            $display("FAIL op_operands[%0d]: got %h/%h want %h/%h", i, div_dividend, div_divisor,
                     v[i].ma, v[i].mb);
         end
         wait_res(n);
         n_checks++;
         if (n != 7) begin
            n_errors++;
            $display("FAIL op_latency[%0d]: got %0d want 7", i, n);
         end
         n_checks++;
         if (res_data !== v[i].exp || res_tag !== v[i].tag || res_src !== 2'(v[i].src)) begin
            n_errors++;
            $display("FAIL op_result[%0d]: got data=%h tag=%h src=%0d want %h/%h/%0d", i,
                     res_data, res_tag, res_src, v[i].exp, v[i].tag, v[i].src);
         end
         handshake();
         n_checks++;
         if (res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL op_release[%0d]: got res_valid=%b want 0", i, res_valid);
         end
      end
   endtask

   task automatic test_special();
      vec_t v[6];
      bit ok;
      int n;
      int s0;
      v[0] = '{0, 2'b01, 32'd5,         32'd0,         32'd0, 32'd0, 32'hFFFF_FFFF, 4'h6};
      v[1] = '{1, 2'b10, 32'd5,         32'd0,         32'd0, 32'd0, 32'd5,         4'h7};
      v[2] = '{0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 4'h8};
      v[3] = '{1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,         4'hB};
      v[4] = '{0, 2'b10, 32'hFFFF_FFF9, 32'd0,         32'd0, 32'd0, 32'hFFFF_FFF9, 4'hD};
      v[5] = '{1, 2'b00, 32'd5,         32'd0,         32'd0, 32'd0, 32'hFFFF_FFFF, 4'hE};
      for (int i = 0; i < 6; i++) begin
         s0 = start_cnt;
         issue(v[i].src, v[i].op, v[i].a, v[i].b, v[i].tag, ok);
         wait_res(n);
         n_checks++;
         if (!ok || n != 1) begin
            n_errors++;
            $display("FAIL special_latency[%0d]: got granted=%b latency=%0d want 1/1", i, ok, n);
         end
         n_checks++;
         if (res_data !== v[i].exp || res_tag !== v[i].tag || res_src !== 2'(v[i].src)) begin
            n_errors++;
            $display("FAIL special_result[%0d]: got data=%h tag=%h src=%0d want %h/%h/%0d", i,
                     res_data, res_tag, res_src, v[i].exp, v[i].tag, v[i].src);
         end
         handshake();
         @(negedge clk);
         n_checks++;
         if (start_cnt != s0) begin
            n_errors++;
            $display("FAIL special_no_start[%0d]: got %0d core starts want 0", i, start_cnt - s0);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int n;
      issue(0, 2'b00, 32'd100, 32'hFFFF_FFFB, 4'hF, ok);
      drive_req(1, 2'b01, 32'd1, 32'd1, 4'h0);
      wait_res(n);
      n_checks++;
      if (!ok || n != 7) begin
         n_errors++;
         $display("FAIL bp_latency: got granted=%b latency=%0d want 1/7", ok, n);
      end
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFEC || res_tag !== 4'hF ||
             req_ready !== '0) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%h tag=%h ready=%b want 1/ffffffec/f/00",
                     k, res_valid, res_data, res_tag, req_ready);
         end
         @(negedge clk);
      end
      req_valid = '0;
      handshake();
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_release: got res_valid=%b want 0", res_valid);
      end
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      int n;
      issue(0, 2'b01, 32'd100, 32'd7, 4'h3, ok);
      n_checks++;
      if (!ok || div_start !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_start: got granted=%b div_start=%b want 1/1", ok, div_start);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      n_checks++;
      if (res_valid !== 1'b0 || res_data !== '0 || res_tag !== '0) begin
         n_errors++;
         $display("FAIL mid_reset: got valid=%b data=%h tag=%h want 0/0/0", res_valid, res_data,
                  res_tag);
      end
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (res_valid !== 1'b0 || div_start !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_stale[%0d]: got res_valid=%b div_start=%b want 0/0", k, res_valid,
                     div_start);
         end
         @(negedge clk);
      end
      issue(1, 2'b00, 32'hFFFF_FFF9, 32'd2, 4'h6, ok);
      wait_res(n);
      n_checks++;
      if (!ok || n != 7 || res_data !== 32'hFFFF_FFFD || res_tag !== 4'h6) begin
         n_errors++;
         $display("FAIL mid_recover: got granted=%b latency=%0d data=%h tag=%h want 1/7/fffffffd/6",
                  ok, n, res_data, res_tag);
      end
      handshake();
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      res_ready = 1'b0;
      inj_done  = 1'b0;
      test_reset();
      test_round_robin();
      test_normal_ops();
      test_special();
      test_backpressure();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
